// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Pushbutton conditioner. It synchronises a raw bouncing button,
//               debounces the press and release edges, and produces a debounced
//               level, press/release/long-press strobes and a toggle output.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk_50MHz,
    input  logic reset_n,
    input  logic button_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic toggle_state
);

    // Both counters share one width. It holds LONG_PRESS_CYCLES, the saturated
    // hold value, and DEBOUNCE_CYCLES, which is always below it.
    localparam int c_CW = $clog2(LONG_PRESS_CYCLES) + 1;

    localparam logic [c_CW-1:0] c_DB_LAST    = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_DB_LOAD    = c_CW'(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0] c_LONG_LAST  = c_CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [c_CW-1:0] c_LONG_SAT   = c_CW'(LONG_PRESS_CYCLES);
    localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS_DB  = 3'd1,
        S_PRESSED   = 3'd2,
        S_LONG_HELD = 3'd3,
        S_REL_DB    = 3'd4
    } state_t;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_raw_pressed;

    state_t          r_state;
    logic [c_CW-1:0] r_db_cnt;
    logic [c_CW-1:0] r_hold_cnt;
    logic            r_from_long;
    logic            r_btn_level;
    logic            r_press_pulse;
    logic            r_release_pulse;
    logic            r_long_pulse;
    logic            r_toggle;

    // Two-flop synchroniser. Reset loads the released level so that no press is seen.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw_pressed = r_sync2 ^ ACTIVE_LOW;

    // Debounce/hold state machine. All outputs are registered here.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_from_long     <= 1'b0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_toggle        <= 1'b0;
        end else begin
            // Strobes are high for a single cycle, so they clear unless a transition sets them.
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_raw_pressed) begin
                        r_state  <= S_PRESS_DB;
                        r_db_cnt <= c_ONE;
                    end else begin
                        r_db_cnt <= '0;
                    end
                end

                S_PRESS_DB: begin
                    if (!w_raw_pressed) begin
                        r_state  <= S_IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state       <= S_PRESSED;
                        r_db_cnt      <= '0;
                        r_hold_cnt    <= c_DB_LOAD;
                        r_btn_level   <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_toggle      <= ~r_toggle;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_ONE;
                    end
                end

                S_PRESSED: begin
                    // A release takes priority. hold_cnt is frozen while the
                    // release is being debounced.
                    if (!w_raw_pressed) begin
                        r_state     <= S_REL_DB;
                        r_db_cnt    <= c_ONE;
                        r_from_long <= 1'b0;
                    end else if (r_hold_cnt == c_LONG_LAST) begin
                        r_state      <= S_LONG_HELD;
                        r_hold_cnt   <= c_LONG_SAT;
                        r_long_pulse <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_ONE;
                    end
                end

                S_LONG_HELD: begin
                    // hold_cnt stays saturated. Only a release can leave this state.
                    if (!w_raw_pressed) begin
                        r_state     <= S_REL_DB;
                        r_db_cnt    <= c_ONE;
                        r_from_long <= 1'b1;
                    end
                end

                S_REL_DB: begin
                    if (w_raw_pressed) begin
                        // This was a release glitch. Go back to where the FSM came from with no strobe.
                        r_state  <= r_from_long ? S_LONG_HELD : S_PRESSED;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state         <= S_IDLE;
                        r_db_cnt        <= '0;
                        r_hold_cnt      <= '0;
                        r_btn_level     <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_ONE;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    assign btn_level        = r_btn_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign toggle_state     = r_toggle;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. Expected strobes
//               (kind and cycle) are queued as stimulus is applied, and a
//               monitor compares them against the strobes the DUT produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_DB   = 4;
    localparam int c_LONG = 20;

    localparam int c_K_PRESS   = 0;
    localparam int c_K_RELEASE = 1;
    localparam int c_K_LONG    = 2;

    logic clk_50MHz = 1'b0;
    logic reset_n;
    logic button_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;
    logic toggle_state;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (c_DB),
        .LONG_PRESS_CYCLES (c_LONG),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk_50MHz        (clk_50MHz),
        .reset_n          (reset_n),
        .button_in        (button_in),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .toggle_state     (toggle_state)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Go to 1 time unit after the rising edge that starts cycle c.
    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    // Go to the falling edge inside cycle c.
    task automatic at_neg(input int c);
        to_cycle(c);
        @(negedge clk_50MHz);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   int'(btn_level),        0);
        check({tag, "_press"},   int'(press_pulse),      0);
        check({tag, "_release"}, int'(release_pulse),    0);
        check({tag, "_long"},    int'(long_press_pulse), 0);
        check({tag, "_toggle"},  int'(toggle_state),     0);
    endtask

    // Strobe monitor. Each strobe must be alone in its cycle and must match the next queued expectation.
    int  m_n;
    int  m_kind;
    ev_t m_e;
    always @(negedge clk_50MHz) begin
        m_n = int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse);
        if (m_n != 0) begin
            check("strobe_exclusive", m_n, 1);
            m_kind = press_pulse ? c_K_PRESS : (release_pulse ? c_K_RELEASE : c_K_LONG);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", m_kind, -1);
            end else begin
                m_e = exp_q.pop_front();
                check("strobe_kind", m_kind, m_e.kind);
                check("strobe_cycle", cyc, m_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        button_in = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_50MHz);
        check_all_zero("reset");
        to_cycle(4);
        reset_n = 1'b1;

        // Clean press, then hold past the long-press point, then release
        to_cycle(10);
        button_in = 1'b0;
        push_ev(c_K_PRESS, 16);
        push_ev(c_K_LONG, 32);
        at_neg(15);
        check("clean_level_before", int'(btn_level), 0);
        at_neg(16);
        check("clean_level", int'(btn_level), 1);
        check("clean_toggle", int'(toggle_state), 1);
        to_cycle(46);
        button_in = 1'b1;
        push_ev(c_K_RELEASE, 52);
        at_neg(51);
        check("long_level_held", int'(btn_level), 1);
        at_neg(52);
        check("long_level_released", int'(btn_level), 0);
        check("long_toggle", int'(toggle_state), 1);

        // Bouncing press: 0,1,0,1,0 and then held
        to_cycle(60); button_in = 1'b0;
        push_ev(c_K_PRESS, 70);
        to_cycle(61); button_in = 1'b1;
        to_cycle(62); button_in = 1'b0;
        to_cycle(63); button_in = 1'b1;
        to_cycle(64); button_in = 1'b0;
        at_neg(69);
        check("bounce_level_before", int'(btn_level), 0);
        check("bounce_toggle_before", int'(toggle_state), 1);
        at_neg(70);
        check("bounce_level", int'(btn_level), 1);
        check("bounce_toggle", int'(toggle_state), 0);
        to_cycle(72);
        button_in = 1'b1;
        push_ev(c_K_RELEASE, 78);
        at_neg(79);
        check("bounce_level_released", int'(btn_level), 0);
        check("bounce_toggle_after", int'(toggle_state), 0);

        // Release glitch while PRESSED. The long press is delayed by the frozen hold cycles.
        to_cycle(90);
        button_in = 1'b0;
        push_ev(c_K_PRESS, 96);
        at_neg(96);
        check("glitch_toggle_press", int'(toggle_state), 1);
        to_cycle(98);  button_in = 1'b1;
        to_cycle(100); button_in = 1'b0;
        push_ev(c_K_LONG, 115);
        at_neg(102);
        check("glitch_level_mid", int'(btn_level), 1);
        at_neg(104);
        check("glitch_level_after", int'(btn_level), 1);
        check("glitch_toggle_after", int'(toggle_state), 1);

        // Reset while LONG_HELD, with the button held through the reset
        to_cycle(120);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        to_cycle(123);
        reset_n = 1'b1;
        push_ev(c_K_PRESS, 129);
        at_neg(128);
        check("postreset_level_before", int'(btn_level), 0);
        check("postreset_toggle_before", int'(toggle_state), 0);
        at_neg(129);
        check("postreset_level", int'(btn_level), 1);
        check("postreset_toggle", int'(toggle_state), 1);
        to_cycle(132);
        button_in = 1'b1;
        push_ev(c_K_RELEASE, 138);
        at_neg(140);
        check("final_level", int'(btn_level), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
